// File: rtl/alu_sequencer_if.sv
// Operator-facing bus of the ALU sequencer: advance button, operand/op inputs, result outputs.
interface alu_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             next;
    logic [2:0]       ms;
    logic [WIDTH-1:0] din;
    logic             done;
    logic [2:0]       cs;
    logic [WIDTH-1:0] alu_out;
    logic             ovf;

    modport master (output next, ms, din, input done, cs, alu_out, ovf);
    modport slave  (input next, ms, din, output done, cs, alu_out, ovf);
endinterface

// File: rtl/alu_sequencer.sv
// Button-stepped ALU: capture opA, opB, op on successive advance edges, then execute.
// Result registered one cycle after op capture; no backpressure, operator paces every step.
module alu_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           clear_n,
    alu_sequencer_if.slave bus
);
    localparam logic [2:0] S_A    = 3'b000;
    localparam logic [2:0] S_B    = 3'b001;
    localparam logic [2:0] S_OP   = 3'b010;
    localparam logic [2:0] S_EXEC = 3'b011;
    localparam logic [2:0] S_DONE = 3'b100;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;

    localparam logic [WIDTH-1:0] W_VAL = WIDTH[WIDTH-1:0];

    logic [2:0]         state_q, state_d;
    logic               next_q;
    logic [WIDTH-1:0]   opa_q, opb_q;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   alu_out_q, alu_out_d;
    logic               ovf_q, ovf_d;
    logic               adv;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic               shift_oor;

    // next_q resets high so a button held through reset release needs a fresh press
    assign adv = bus.next & ~next_q;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= S_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_A:     if (adv) state_d = S_B;
            S_B:     if (adv) state_d = S_OP;
            S_OP:    if (adv) state_d = S_EXEC;
            S_EXEC:  state_d = S_DONE;
            S_DONE:  if (adv) state_d = S_A;
            default: state_d = S_A;
        endcase
    end

    always_comb begin
        bus.cs   = state_q;
        bus.done = (state_q == S_DONE);
    end

    always_comb begin
        sum       = {1'b0, opa_q} + {1'b0, opb_q};
        prod      = {{WIDTH{1'b0}}, opa_q} * {{WIDTH{1'b0}}, opb_q};
        shift_oor = (opb_q >= W_VAL);
        alu_out_d = '0;
        ovf_d     = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_out_d = sum[WIDTH-1:0];
                ovf_d     = sum[WIDTH];
            end
            OP_SUB: begin
                alu_out_d = opa_q - opb_q;
                ovf_d     = (opa_q < opb_q);
            end
            OP_AND: alu_out_d = opa_q & opb_q;
            OP_OR:  alu_out_d = opa_q | opb_q;
            OP_XOR: alu_out_d = opa_q ^ opb_q;
            OP_SHL: begin
                if (shift_oor) ovf_d = 1'b1;
                else           alu_out_d = opa_q << opb_q;
            end
            OP_SHR: begin
                if (shift_oor) ovf_d = 1'b1;
                else           alu_out_d = opa_q >> opb_q;
            end
            default: begin
                alu_out_d = prod[WIDTH-1:0];
                ovf_d     = |prod[2*WIDTH-1:WIDTH];
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            next_q    <= 1'b1;
            opa_q     <= '0;
            opb_q     <= '0;
            op_q      <= OP_ADD;
            alu_out_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            next_q <= bus.next;
            if (state_q == S_A && adv)  opa_q <= bus.din;
            if (state_q == S_B && adv)  opb_q <= bus.din;
            if (state_q == S_OP && adv) op_q  <= bus.ms;
            if (state_q == S_EXEC) begin
                alu_out_q <= alu_out_d;
                ovf_q     <= ovf_d;
            end
        end
    end

    assign bus.alu_out = alu_out_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: 16-bit and 8-bit instances stepped in lockstep from one stimulus.
module tb_alu_sequencer;
    logic        clk = 1'b0;
    logic        clear_n;
    logic        nxt;
    logic [2:0]  ms;
    logic [15:0] din;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    alu_sequencer_if #(.WIDTH(16)) if16();
    alu_sequencer_if #(.WIDTH(8))  if8();

    assign if16.next = nxt;
    assign if16.ms   = ms;
    assign if16.din  = din;
    assign if8.next  = nxt;
    assign if8.ms    = ms;
    assign if8.din   = din[7:0];

    alu_sequencer #(.WIDTH(16)) dut16 (.clk(clk), .clear_n(clear_n), .bus(if16));
    alu_sequencer #(.WIDTH(8))  dut8  (.clk(clk), .clear_n(clear_n), .bus(if8));

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference arithmetic: results computed as integers modulo 2^w
    function automatic void model(input int w, input longint unsigned a, input longint unsigned b,
                                  input logic [2:0] m, output longint unsigned r, output logic v);
        longint unsigned md;
        longint unsigned p;
        md = 64'd1 << w;
        a  = a % md;
        b  = b % md;
        r  = 0;
        v  = 1'b0;
        case (m)
            3'd0: begin p = a + b; r = p % md; v = (p >= md); end
            3'd1: begin r = (a + md - b) % md; v = (a < b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: if (b >= longint'(w)) v = 1'b1; else r = (a * (64'd1 << b)) % md;
            3'd6: if (b >= longint'(w)) v = 1'b1; else r = a / (64'd1 << b);
            default: begin p = a * b; r = p % md; v = (p >= md); end
        endcase
    endfunction

    task automatic press();
        @(posedge clk); #1 nxt = 1'b1;
        @(posedge clk); #1 nxt = 1'b0;
    endtask

    // Leaves both DUTs in S_DONE, sampled 1 time unit after the result edge
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] m);
        ms  = 3'($urandom);
        din = a;
        press();
        din = b;
        press();
        din = 16'($urandom);
        ms  = m;
        press();
        ms  = 3'($urandom);
        din = 16'($urandom);
        n_cmp++;
        if ({if16.cs, if16.done} !== {3'b011, 1'b0}) begin
            n_bad++;
            $display("FAIL exec_state: cs/done=%b required 0110", {if16.cs, if16.done});
        end
        @(posedge clk); #1;
    endtask

    task automatic check_result(input logic [15:0] a, input logic [15:0] b, input logic [2:0] m,
                                input string tag);
        longint unsigned r16, r8;
        logic            v16, v8;
        model(16, a, b, m, r16, v16);
        model(8, a, b, m, r8, v8);
        n_cmp++;
        if ({if16.cs, if16.done, if16.ovf, if16.alu_out} !== {3'b100, 1'b1, v16, r16[15:0]}) begin
            n_bad++;
            $display("FAIL %s w16 a=%h b=%h op=%0d: cs=%b done=%b ovf=%b out=%h required cs=100 done=1 ovf=%b out=%h",
                     tag, a, b, m, if16.cs, if16.done, if16.ovf, if16.alu_out, v16, r16[15:0]);
        end
        n_cmp++;
        if ({if8.cs, if8.done, if8.ovf, if8.alu_out} !== {3'b100, 1'b1, v8, r8[7:0]}) begin
            n_bad++;
            $display("FAIL %s w8 a=%h b=%h op=%0d: cs=%b done=%b ovf=%b out=%h required cs=100 done=1 ovf=%b out=%h",
                     tag, a[7:0], b[7:0], m, if8.cs, if8.done, if8.ovf, if8.alu_out, v8, r8[7:0]);
        end
    endtask

    task automatic finish_op(input string tag);
        logic [15:0] held;
        held = if16.alu_out;
        press();
        n_cmp++;
        if ({if16.cs, if16.done, if16.alu_out} !== {3'b000, 1'b0, held}) begin
            n_bad++;
            $display("FAIL %s return: cs=%b done=%b out=%h required cs=000 done=0 out=%h",
                     tag, if16.cs, if16.done, if16.alu_out, held);
        end
    endtask

    task automatic test_reset();
        clear_n = 1'b0;
        nxt     = 1'b0;
        ms      = 3'd0;
        din     = 16'd0;
        #12;
        n_cmp++;
        if ({if16.cs, if16.done, if16.ovf, if16.alu_out} !== 22'd0) begin
            n_bad++;
            $display("FAIL reset16: cs=%b done=%b ovf=%b out=%h required all zero",
                     if16.cs, if16.done, if16.ovf, if16.alu_out);
        end
        n_cmp++;
        if ({if8.cs, if8.done, if8.ovf, if8.alu_out} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset8: cs=%b done=%b ovf=%b out=%h required all zero",
                     if8.cs, if8.done, if8.ovf, if8.alu_out);
        end
        clear_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [15:0] ta [7] = '{16'h0001, 16'h0001, 16'h0005, 16'h0001, 16'h0001, 16'h0100, 16'h00FF};
        logic [15:0] tb [7] = '{16'h0003, 16'h0003, 16'h0003, 16'd16,   16'd15,   16'h0100, 16'h0001};
        logic [2:0]  tm [7] = '{3'd0,     3'd1,     3'd1,     3'd5,     3'd5,     3'd7,     3'd0};
        logic [15:0] er [7] = '{16'h0004, 16'hFFFE, 16'h0002, 16'h0000, 16'h8000, 16'h0000, 16'h0100};
        logic        ev [7] = '{1'b0,     1'b1,     1'b0,     1'b1,     1'b0,     1'b1,     1'b0};
        for (int i = 0; i < 7; i++) begin
            run_op(ta[i], tb[i], tm[i]);
            n_cmp++;
            if ({if16.cs, if16.done, if16.ovf, if16.alu_out} !== {3'b100, 1'b1, ev[i], er[i]}) begin
                n_bad++;
                $display("FAIL directed%0d: cs=%b done=%b ovf=%b out=%h required cs=100 done=1 ovf=%b out=%h",
                         i, if16.cs, if16.done, if16.ovf, if16.alu_out, ev[i], er[i]);
            end
            finish_op("directed");
        end
    endtask

    task automatic test_hold();
        din = 16'h1234;
        @(posedge clk); #1 nxt = 1'b1;
        @(posedge clk); #1 din = 16'hBEEF;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (if16.cs !== 3'b001) begin
            n_bad++;
            $display("FAIL hold_single_advance: cs=%b required 001", if16.cs);
        end
        nxt = 1'b0;
        din = 16'h0000;
        press();
        ms = 3'd3;
        press();
        @(posedge clk); #1;
        n_cmp++;
        if ({if16.done, if16.alu_out} !== {1'b1, 16'h1234}) begin
            n_bad++;
            $display("FAIL hold_opa: done=%b out=%h required done=1 out=1234", if16.done, if16.alu_out);
        end
        finish_op("hold");
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        logic [2:0]  m;
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            b = (i % 2 == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            m = 3'($urandom);
            run_op(a, b, m);
            check_result(a, b, m, "random");
            finish_op("random");
        end
    endtask

    task automatic test_reset_exec();
        run_op(16'h0007, 16'h0009, 3'd0);
        finish_op("pre_reset");
        din = 16'h0011;
        press();
        din = 16'h0022;
        press();
        ms = 3'd7;
        press();
        clear_n = 1'b0;
        nxt     = 1'b1;
        #2;
        n_cmp++;
        if ({if16.cs, if16.done, if16.ovf, if16.alu_out, if8.cs, if8.done, if8.alu_out} !== 33'd0) begin
            n_bad++;
            $display("FAIL reset_in_exec: cs=%b done=%b ovf=%b out=%h cs8=%b done8=%b out8=%h required all zero",
                     if16.cs, if16.done, if16.ovf, if16.alu_out, if8.cs, if8.done, if8.alu_out);
        end
        @(posedge clk); #1 clear_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({if16.cs, if16.done, if16.alu_out} !== 20'd0) begin
            n_bad++;
            $display("FAIL held_next_after_reset: cs=%b done=%b out=%h required all zero",
                     if16.cs, if16.done, if16.alu_out);
        end
        nxt = 1'b0;
        press();
        n_cmp++;
        if (if16.cs !== 3'b001) begin
            n_bad++;
            $display("FAIL fresh_press_after_reset: cs=%b required 001", if16.cs);
        end
        clear_n = 1'b0;
        #2 clear_n = 1'b1;
    endtask

    task automatic test_width8();
        run_op(16'h00FF, 16'h0001, 3'd0);
        n_cmp++;
        if ({if8.cs, if8.done, if8.ovf, if8.alu_out} !== {3'b100, 1'b1, 1'b1, 8'h00}) begin
            n_bad++;
            $display("FAIL w8_add_carry: cs=%b done=%b ovf=%b out=%h required cs=100 done=1 ovf=1 out=00",
                     if8.cs, if8.done, if8.ovf, if8.alu_out);
        end
        press();
        n_cmp++;
        if ({if8.cs, if8.done, if8.alu_out} !== {3'b000, 1'b0, 8'h00}) begin
            n_bad++;
            $display("FAIL w8_return: cs=%b done=%b out=%h required cs=000 done=0 out=00",
                     if8.cs, if8.done, if8.alu_out);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_random();
        test_reset_exec();
        test_width8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
